// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 bit mux between eight requesters,
// with bursts of up to MAX_BURST accepted beats per grant on a valid/ready port.
module mux8_rr_sched #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] ack,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept_s;
    logic       last_beat_s;
    logic [2:0] sel_next_s;
    logic [3:0] win_ptr_s;
    logic [3:0] win_rr_s;

    // Returns {found, index} of the first set request scanning start, start+1, ... with 3-bit wrap.
    function automatic logic [3:0] pick_winner(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign out_valid   = (state_q == GRANT) & req[sel_q];
    assign accept_s    = out_valid & out_ready;
    assign last_beat_s = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign sel_next_s  = sel_q + 3'd1;
    assign win_ptr_s   = pick_winner(req, ptr_q);
    assign win_rr_s    = pick_winner(req, sel_next_s);

    assign sel      = sel_q;
    assign gnt      = gnt_q;
    assign out_data = din[sel_q];
    assign ack      = accept_s ? gnt_q : 8'h00;
    assign busy     = (state_q == GRANT);

    // Next-state logic: arbitration from ptr in IDLE, burst/release handling in GRANT.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_ptr_s[3]) begin
                    state_d = GRANT;
                    sel_d   = win_ptr_s[2:0];
                    gnt_d   = 8'd1 << win_ptr_s[2:0];
                    cnt_d   = '0;
                end else begin
                    gnt_d   = 8'h00;
                end
            end
            GRANT: begin
                // Withdrawal and burst exhaustion both rotate priority past the current grantee;
                // the grantee itself is scanned last, so it is regranted only as sole requester.
                if (!req[sel_q] || (accept_s && last_beat_s)) begin
                    ptr_d = sel_next_s;
                    if (win_rr_s[3]) begin
                        sel_d = win_rr_s[2:0];
                        gnt_d = 8'd1 << win_rr_s[2:0];
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 8'h00;
                    end
                end else if (accept_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    // State, grant, pointer and beat-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: a reference model pushes expected outputs
// each driven cycle; they are popped and compared at the falling edge.
module tb_mux8_rr_sched;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, din, gnt, ack;
    logic [2:0] sel;
    logic       out_data, out_valid, out_ready, busy;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       data;
        logic [7:0] ack;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    bit         m_st;
    int         m_sel, m_ptr, m_cnt;
    logic [7:0] m_gnt;

    mux8_rr_sched #(.MAX_BURST(MB), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .sel(sel), .gnt(gnt),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_st = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_gnt = 8'h00;
    endtask

    task automatic model_update(input logic [7:0] r, input bit acc);
        int w;
        if (!m_st) begin
            w = rr_pick(r, m_ptr);
            if (w >= 0) begin
                m_st = 1'b1; m_sel = w; m_gnt = 8'd1 << w; m_cnt = 0;
            end
        end else if (!r[m_sel] || (acc && m_cnt == MB - 1)) begin
            m_ptr = (m_sel + 1) % 8;
            w = rr_pick(r, m_ptr);
            if (w >= 0) begin
                m_sel = w; m_gnt = 8'd1 << w; m_cnt = 0;
            end else begin
                m_st = 1'b0; m_gnt = 8'h00;
            end
        end else if (acc) begin
            m_cnt++;
        end
    endtask

    // Drive one cycle of stimulus, score it at the falling edge, advance the model at the rising edge.
    task automatic drive_cycle(input logic [7:0] r, input logic [7:0] d, input logic rdy);
        exp_t e, o;
        req = r; din = d; out_ready = rdy;
        e.gnt   = m_gnt;
        e.sel   = 3'(m_sel);
        e.busy  = m_st;
        e.valid = m_st && r[m_sel];
        e.data  = d[m_sel];
        e.ack   = (e.valid && rdy) ? (8'd1 << m_sel) : 8'h00;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            o = sb_q.pop_front();
            check_val("gnt",       32'(gnt),       32'(o.gnt));
            check_val("sel",       32'(sel),       32'(o.sel));
            check_val("out_valid", 32'(out_valid), 32'(o.valid));
            check_val("out_data",  32'(out_data),  32'(o.data));
            check_val("ack",       32'(ack),       32'(o.ack));
            check_val("busy",      32'(busy),      32'(o.busy));
        end
        @(posedge clk);
        model_update(r, e.valid && rdy);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req = 8'hFF; din = 8'h00; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_gnt",   32'(gnt),       32'h00);
        check_val("rst_sel",   32'(sel),       32'h0);
        check_val("rst_valid", 32'(out_valid), 32'h0);
        check_val("rst_ack",   32'(ack),       32'h00);
        check_val("rst_busy",  32'(busy),      32'h0);
        rst_n = 1'b1;

        // All requesting: index 0 first, four beats, then index 1 with no idle gap.
        drive_cycle(8'hFF, 8'hA5, 1'b1);
        check_val("t1_first_gnt", 32'(gnt), 32'h01);
        repeat (MB) drive_cycle(8'hFF, 8'hA5, 1'b1);
        check_val("t1_second_gnt", 32'(gnt), 32'h02);
        check_val("t1_no_idle",    32'(busy), 32'h1);
        repeat (6) drive_cycle(8'hFF, 8'h5A, 1'b1);

        // Single requester is regranted every burst.
        repeat (12) drive_cycle(8'h20, 8'h20, 1'b1);
        check_val("t2_sel", 32'(sel), 32'h5);
        check_val("t2_data", 32'(out_data), 32'h1);

        // Backpressure on index 3.
        repeat (2) drive_cycle(8'h00, 8'h00, 1'b1);
        drive_cycle(8'h08, 8'h08, 1'b0);
        repeat (10) drive_cycle(8'h08, 8'h08, 1'b0);
        check_val("t3_gnt_held", 32'(gnt), 32'h08);
        drive_cycle(8'h08, 8'h08, 1'b1);
        drive_cycle(8'h08, 8'h08, 1'b1);

        // Early release of index 2 hands over to 6 ahead of 0.
        repeat (2) drive_cycle(8'h00, 8'h00, 1'b1);
        drive_cycle(8'h04, 8'hFF, 1'b1);
        repeat (2) drive_cycle(8'h44, 8'hFF, 1'b1);
        drive_cycle(8'h41, 8'hFF, 1'b1);
        check_val("t4_gnt", 32'(gnt), 32'h40);

        // Wrap: ptr=7 grants 7, then 0, then 7 again.
        drive_cycle(8'h81, 8'h80, 1'b1);
        check_val("t5_gnt7", 32'(gnt), 32'h80);
        repeat (MB) drive_cycle(8'h81, 8'h80, 1'b1);
        check_val("t5_gnt0", 32'(gnt), 32'h01);
        repeat (MB) drive_cycle(8'h81, 8'h01, 1'b1);
        check_val("t5_gnt7b", 32'(gnt), 32'h80);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            drive_cycle(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset mid-burst clears outputs without a clock edge.
        drive_cycle(8'hFF, 8'hFF, 1'b1);
        drive_cycle(8'hFF, 8'hFF, 1'b1);
        check_val("t6_valid_before", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_valid", 32'(out_valid), 32'h0);
        check_val("t6_gnt",   32'(gnt),       32'h00);
        check_val("t6_ack",   32'(ack),       32'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(8'hFF, 8'h00, 1'b1);
        check_val("t6_restart_gnt", 32'(gnt), 32'h01);
        repeat (6) drive_cycle(8'hFF, 8'h0F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
